// File: rtl/jk_bank_ctrl_pkg.sv
// Shared opcodes, FSM state type and opcode classification for jk_bank_ctrl.
// Opcode 110 is COUNT_DOWN only when JK_BANK_CTRL_COUNT_DOWN_EN is defined.
package jk_bank_pkg;

    localparam logic [2:0] OP_NOP        = 3'b000;
    localparam logic [2:0] OP_CLEAR      = 3'b001;
    localparam logic [2:0] OP_SET_ALL    = 3'b010;
    localparam logic [2:0] OP_LOAD       = 3'b011;
    localparam logic [2:0] OP_TOGGLE     = 3'b100;
    localparam logic [2:0] OP_COUNT_UP   = 3'b101;
    localparam logic [2:0] OP_COUNT_DOWN = 3'b110;
    localparam logic [2:0] OP_SHIFT      = 3'b111;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    // Multi-step ops run for cmd_len edges; everything else takes one edge.
    function automatic logic op_is_multi(input logic [2:0] op);
`ifdef JK_BANK_CTRL_COUNT_DOWN_EN
        return (op == OP_COUNT_UP) || (op == OP_SHIFT) || (op == OP_COUNT_DOWN);
`else
        return (op == OP_COUNT_UP) || (op == OP_SHIFT);
`endif
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
`ifdef JK_BANK_CTRL_COUNT_DOWN_EN
        return (op == op);
`else
        return (op != OP_COUNT_DOWN);
`endif
    endfunction

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Command channel of jk_bank_ctrl: valid/ready handshake plus op, arg and length.
interface jk_bank_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic [LEN_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        input  cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_ctrl_bank.sv
// Bank of WIDTH JK flip-flops with per-bit j/k drive and async active-low clear.
module jk_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_inverse
);

    // JK characteristic: Q+ = J&~Q | ~K&Q (00 hold, 01 reset, 10 set, 11 toggle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

    assign q_inverse = ~q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven sequencer for a JK flip-flop bank: FSM, step counter and J/K decode.
// Optional down-counter on opcode 110 enabled by JK_BANK_CTRL_COUNT_DOWN_EN.
module jk_bank_ctrl
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_bank_ctrl_if.slave    cmd,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_inverse,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] arg_r;
    logic [LEN_W-1:0] steps;
    logic             ready_r;
    logic             last_edge;
    logic             drive_en;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] shin;
`ifdef JK_BANK_CTRL_COUNT_DOWN_EN
    logic [WIDTH-1:0] borrow;
`endif

    assign cmd.cmd_ready = ready_r;

    // A zero-length multi-step op still spends one edge, but with J/K held off.
    assign last_edge = !op_is_multi(op_r) || (steps == '0) || (steps == LEN_W'(1));
    assign drive_en  = op_is_multi(op_r) ? (steps != '0) : op_is_legal(op_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_r    <= OP_NOP;
            arg_r   <= '0;
            steps   <= '0;
            ready_r <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_r    <= cmd.cmd_op;
                        arg_r   <= cmd.cmd_arg;
                        steps   <= op_is_multi(cmd.cmd_op) ? cmd.cmd_len : '0;
                        state   <= EXEC;
                        ready_r <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                EXEC: begin
                    if (last_edge) begin
                        state   <= IDLE;
                        steps   <= '0;
                        ready_r <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        err     <= !op_is_legal(op_r);
                    end else begin
                        steps <= steps - LEN_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Ripple toggle-enable chains for counting and the shifted-in vector.
    always_comb begin
        carry    = '0;
        shin     = '0;
        carry[0] = 1'b1;
        shin[0]  = arg_r[0];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            carry[i] = carry[i-1] & q[i-1];
            shin[i]  = q[i-1];
        end
    end

`ifdef JK_BANK_CTRL_COUNT_DOWN_EN
    always_comb begin
        borrow    = '0;
        borrow[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            borrow[i] = borrow[i-1] & ~q[i-1];
        end
    end
`endif

    always_comb begin
        j = '0;
        k = '0;
        if ((state == EXEC) && drive_en) begin
            case (op_r)
                OP_CLEAR: begin
                    k = '1;
                end
                OP_SET_ALL: begin
                    j = '1;
                end
                OP_LOAD: begin
                    j = arg_r;
                    k = ~arg_r;
                end
                OP_TOGGLE: begin
                    j = arg_r;
                    k = arg_r;
                end
                OP_COUNT_UP: begin
                    j = carry;
                    k = carry;
                end
`ifdef JK_BANK_CTRL_COUNT_DOWN_EN
                OP_COUNT_DOWN: begin
                    j = borrow;
                    k = borrow;
                end
`endif
                OP_SHIFT: begin
                    j = shin;
                    k = ~shin;
                end
                default: begin
                    j = '0;
                    k = '0;
                end
            endcase
        end
    end

    jk_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .j        (j),
        .k        (k),
        .q        (q),
        .q_inverse(q_inverse)
    );

endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Command-driven sequencer for a bank of WIDTH JK flip-flops. Accepts one operation at a time over a valid/ready handshake, translates it into per-bit J/K drive, and steps the bank for one or more clock edges. Used wherever the design needs a JK-built register, counter or shift register under host control rather than hand-wired J/K inputs.

## Interface
- WIDTH, 4: number of JK flip-flops in the bank (1..32)
- LEN_W, 8: width of the step-count field
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  3  operation code (below)
- cmd_arg  input  WIDTH  load value / toggle mask / serial-in bit (arg[0])
- cmd_len  input  LEN_W  step count for COUNT_UP, SHIFT, COUNT_DOWN
- q  output  WIDTH  flip-flop bank state
- q_inverse  output  WIDTH  always ~q
- busy  output  1  executing a command
- done  output  1  one-cycle pulse: command finished
- err  output  1  one-cycle pulse with done: command was illegal

## Operation
- Opcodes: 000 NOP (J=K=0), 001 CLEAR (J=0,K=1), 010 SET_ALL (J=1,K=0), 011 LOAD (J=arg,K=~arg), 100 TOGGLE (J=K=arg), 101 COUNT_UP, 110 COUNT_DOWN (config-gated), 111 SHIFT.
- COUNT_UP: J_i=K_i=AND(q[i-1:0]), bit 0 always toggles; wraps all-ones -> 0.
- COUNT_DOWN: J_i=K_i=AND(~q[i-1:0]); wraps 0 -> all-ones.
- SHIFT: left shift; bit i loads q[i-1] via J=q[i-1],K=~q[i-1]; bit 0 loads arg[0]; MSB discarded.
- FSM states: IDLE, EXEC.
  - IDLE: cmd_ready=1, busy=0, bank held (J=K=0). Handshake (cmd_valid&&cmd_ready at edge) latches op/arg/len, goes EXEC.
  - EXEC: cmd_ready=0, busy=1. Each edge applies J/K for latched op and decrements remaining steps. Single-step ops (000–100, illegal) take exactly one edge. Multi-step ops take cmd_len edges; cmd_len=0 -> one edge with J=K=0 (no change).
  - Last EXEC edge -> IDLE; done registered high for the following cycle.
- Illegal op: holds bank one edge, done and err pulse together.
- cmd_op/arg/len ignored outside handshake edge; changing them during EXEC has no effect.
- Reset (any time, incl. mid-EXEC): q=0, q_inverse=all-ones, FSM IDLE, step counter 0, done=0, err=0, busy=0, cmd_ready=1; no handshake while rst_n low. Aborted command is lost, no done.

## Timing
- Edge N: handshake. Edge N+1: first q update. Single-step op: q and done both visible after edge N+1.
- Multi-step op of length L≥1: q updates at edges N+1..N+L; done high in cycle after edge N+L.
- cmd_ready returns high the same cycle done is high; back-to-back accept on that edge. Max rate: one single-step command per 2 cycles.
- q_inverse is combinational ~q, zero latency.
- Step counter is LEN_W bits; cmd_len=2^LEN_W-1 must complete without wrap.

## Configuration
- JK_BANK_CTRL_COUNT_DOWN_EN defined: opcode 110 is COUNT_DOWN as above.
- Not defined: 110 is illegal (one-edge hold, done+err); no down-count logic synthesized.

## Structure
- Package jk_bank_pkg: opcode localparams (OP_NOP..OP_SHIFT), FSM state typedef (IDLE, EXEC).
- Sub-module jk_bank: WIDTH JK flip-flops with per-bit j/k vectors, clk, async rst_n clearing q to 0; outputs q, q_inverse. Controller contains FSM, step counter and J/K decode only.

## Test plan
- Reset then LOAD arg=4'b1010 -> q=1010, q_inverse=0101 one edge after handshake, done pulse, err=0.
- q=1010, TOGGLE arg=4'b0110 -> q=1100; then CLEAR -> q=0000; SET_ALL -> q=1111.
- q=1110, COUNT_UP len=3 -> q sequence 1111, 0000, 0001; busy high 3 cycles, done once; back-to-back NOP accepted in done cycle.
- q=0000, SHIFT len=4 arg[0]=1 -> 0001, 0011, 0111, 1111; COUNT_UP len=0 -> q unchanged, done after one edge.
- Opcode 110: with macro, q=0000 len=2 -> 1111, 1110, err=0; without macro -> q unchanged, done+err pulse.
- rst_n low mid COUNT_UP len=10 -> q=0 immediately, no done, cmd_ready=1 after release; new LOAD executes normally.
